echo_capture: RTL and testbench

Receive side of the ultrasonic ranging interface: after the trigger pulse completes, waits for the sensor ECHO line to rise and measures its high time in microseconds using the shared 1 us tick. Converts width to centimetres on the fly (floor of width/US_PER_CM) with no divider. Sits beside the trigger generator under the ranging controller, which pulses i_start on trig_done and consumes o_valid.

---
 rtl/ranging_pkg.sv | 19 +
 rtl/echo_sync_filter.sv | 65 ++++++
 rtl/echo_capture.sv | 133 +++++++++++++
 tb/tb_echo_capture.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ranging_pkg.sv
// Shared ranging constants and echo FSM state encoding.
// Used by the trigger generator, echo capture and ranging controller.
package ranging_pkg;

  localparam int WIDTH_W_DEF     = 16;
  localparam int DIST_W_DEF      = 10;
  localparam int US_PER_CM_DEF   = 58;
  localparam int RISE_TO_US_DEF  = 2000;
  localparam int MAX_ECHO_US_DEF = 38000;
  localparam int FILT_CLKS_DEF   = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_RISE,
    S_MEASURE,
    S_DONE
  } echo_state_e;

endpackage

// File: rtl/echo_sync_filter.sv
// ECHO pin synchronizer and edge detector.
// Define ECHO_FILTER_EN to add a FILT_CLKS-cycle debouncer before edge detection.
module echo_sync_filter import ranging_pkg::*; #(
  parameter int FILT_CLKS = FILT_CLKS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic echo_i,
  output logic rise_o,
  output logic fall_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic lvl;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= echo_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef ECHO_FILTER_EN
  localparam int CW = $clog2(FILT_CLKS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CLKS - 1);

  logic          filt_q;
  logic [CW-1:0] cnt_q;

  // Level flips only after FILT_CLKS consecutive disagreeing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else if (sync2_q != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_q <= sync2_q;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else begin
      cnt_q <= '0;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync2_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= lvl;
  end

  assign rise_o = lvl & ~prev_q;
  assign fall_o = ~lvl & prev_q;

endmodule

// File: rtl/echo_capture.sv
// Ultrasonic echo width capture with on-the-fly us->cm conversion.
// Build with ECHO_FILTER_EN to debounce the ECHO input.
module echo_capture import ranging_pkg::*; #(
  parameter int WIDTH_W     = WIDTH_W_DEF,
  parameter int DIST_W      = DIST_W_DEF,
  parameter int US_PER_CM   = US_PER_CM_DEF,
  parameter int RISE_TO_US  = RISE_TO_US_DEF,
  parameter int MAX_ECHO_US = MAX_ECHO_US_DEF,
  parameter int FILT_CLKS   = FILT_CLKS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               us_tick,
  input  logic               i_start,
  input  logic               i_echo,
  output logic               o_busy,
  output logic               o_valid,
  output logic               o_timeout,
  output logic [WIDTH_W-1:0] o_width_us,
  output logic [DIST_W-1:0]  o_dist_cm
);

  localparam int SUB_W = $clog2(US_PER_CM + 1);
  localparam logic [SUB_W-1:0]   SUB_LAST = SUB_W'(US_PER_CM - 1);
  localparam logic [WIDTH_W-1:0] RISE_LIM = WIDTH_W'(RISE_TO_US);
  localparam logic [WIDTH_W-1:0] MAX_LIM  = WIDTH_W'(MAX_ECHO_US);

  echo_state_e        state_q;
  logic [WIDTH_W-1:0] cnt_q, cnt_d;
  logic [SUB_W-1:0]   sub_q, sub_d;
  logic [DIST_W-1:0]  cm_q, cm_d;
  logic               tmo_q;
  logic               busy_q, valid_q, to_q;
  logic [WIDTH_W-1:0] width_q;
  logic [DIST_W-1:0]  dist_q;
  logic               rise, fall;

  echo_sync_filter #(
    .FILT_CLKS (FILT_CLKS)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .echo_i (i_echo),
    .rise_o (rise),
    .fall_o (fall)
  );

  // Counter values after one more microsecond
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    sub_d = sub_q + 1'b1;
    cm_d  = cm_q;
    if (sub_q == SUB_LAST) begin
      sub_d = '0;
      if (cm_q != '1) cm_d = cm_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sub_q   <= '0;
      cm_q    <= '0;
      tmo_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      to_q    <= 1'b0;
      width_q <= '0;
      dist_q  <= '0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          busy_q <= 1'b0;
          if (i_start && !busy_q) begin
            busy_q  <= 1'b1;
            state_q <= S_WAIT_RISE;
            cnt_q   <= '0;
            sub_q   <= '0;
            cm_q    <= '0;
            tmo_q   <= 1'b0;
          end
        end
        S_WAIT_RISE: begin
          if (rise) begin
            state_q <= S_MEASURE;
            cnt_q   <= '0;
            sub_q   <= '0;
            cm_q    <= '0;
          end else if (us_tick) begin
            cnt_q <= cnt_d;
            if (cnt_d == RISE_LIM) begin
              state_q <= S_DONE;
              tmo_q   <= 1'b1;
              cnt_q   <= '0;
            end
          end
        end
        S_MEASURE: begin
          if (us_tick) begin
            cnt_q <= cnt_d;
            sub_q <= sub_d;
            cm_q  <= cm_d;
          end
          if (fall) begin
            state_q <= S_DONE;
          end else if (us_tick && cnt_d == MAX_LIM) begin
            state_q <= S_DONE;
            tmo_q   <= 1'b1;
            cnt_q   <= MAX_LIM;
            cm_q    <= '1;
          end
        end
        S_DONE: begin
          valid_q <= 1'b1;
          width_q <= cnt_q;
          dist_q  <= cm_q;
          to_q    <= tmo_q;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_busy     = busy_q;
  assign o_valid    = valid_q;
  assign o_timeout  = to_q;
  assign o_width_us = width_q;
  assign o_dist_cm  = dist_q;

endmodule

// File: tb/tb_echo_capture.sv
// Self-checking bench for echo_capture: directed and random echo pulses.
// Adds a glitch-rejection case when ECHO_FILTER_EN is defined.
module tb_echo_capture;

  logic        clk = 1'b0;
  logic        rst, us_tick, i_start, i_echo;
  logic        o_busy, o_valid, o_timeout;
  logic [15:0] o_width_us;
  logic [9:0]  o_dist_cm;

`ifdef ECHO_FILTER_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif

  int P = 12;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int vcnt = 0;
  logic        last_to;
  logic [15:0] last_w;
  logic [9:0]  last_d;

  echo_capture dut (
    .clk        (clk),
    .rst        (rst),
    .us_tick    (us_tick),
    .i_start    (i_start),
    .i_echo     (i_echo),
    .o_busy     (o_busy),
    .o_valid    (o_valid),
    .o_timeout  (o_timeout),
    .o_width_us (o_width_us),
    .o_dist_cm  (o_dist_cm)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      vcnt++;
      last_to = o_timeout;
      last_w  = o_width_us;
      last_d  = o_dist_cm;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  // One clock; us_tick is high on edges whose index is a multiple of P
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    us_tick = ((cyc + 1) % P == 0);
  endtask

  task automatic start_pulse();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  // Echo edges then reach the FSM mid-way between two ticks
  task automatic wait_phase();
    int ph;
    ph = ((P / 2 - LAT) % P + P) % P;
    while (cyc % P != ph) step();
  endtask

  task automatic wait_valid(input string tag, input int bound,
                            input logic to, input int w, input int d);
    int v0;
    int k;
    v0 = vcnt;
    k  = 0;
    while (vcnt == v0 && k < bound) begin
      step();
      k++;
    end
    chk({tag, "_seen"}, 32'(vcnt != v0), 1);
    if (vcnt != v0) begin
      chk({tag, "_to"}, 32'(last_to), 32'(to));
      chk({tag, "_w"}, 32'(last_w), w);
      chk({tag, "_d"}, 32'(last_d), d);
    end
    repeat (3) step();
    chk({tag, "_once"}, vcnt - v0, 1);
    chk({tag, "_idle"}, 32'(o_busy), 0);
  endtask

  task automatic run_pulse(input string tag, input int dly, input int n,
                           input bit coinc, input bit glitch);
    int w;
    start_pulse();
    chk({tag, "_busy"}, 32'(o_busy), 1);
    if (glitch) begin
      step();
      i_echo = 1'b1;
      step();
      step();
      i_echo = 1'b0;
    end
    wait_phase();
    repeat (dly * P) step();
    i_echo = 1'b1;
    repeat (n * P + (coinc ? P / 2 : 0)) step();
    i_echo = 1'b0;
    w = n + (coinc ? 1 : 0);
    wait_valid(tag, 60, 1'b0, w, w / 58);
  endtask

  initial begin
    int v0;
    rst     = 1'b1;
    i_start = 1'b0;
    i_echo  = 1'b0;
    us_tick = 1'b0;
    repeat (4) step();
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_width", 32'(o_width_us), 0);
    chk("rst_dist", 32'(o_dist_cm), 0);
    chk("rst_to", 32'(o_timeout), 0);
    rst = 1'b0;
    step();

    run_pulse("p580", 300, 580, 1'b0, 1'b0);
    run_pulse("p57", 5, 57, 1'b0, 1'b0);
    run_pulse("p116", 5, 116, 1'b0, 1'b0);
    run_pulse("coinc115", 5, 115, 1'b1, 1'b0);

    P = 1;
    start_pulse();
    v0 = vcnt;
    repeat (1990) step();
    chk("rise_to_early", vcnt - v0, 0);
    wait_valid("rise_to", 30, 1'b1, 0, 0);

    start_pulse();
    repeat (3) step();
    i_echo = 1'b1;
    repeat (100) step();
    start_pulse();
    wait_valid("echo_to", 40000, 1'b1, 38000, 1023);
    i_echo = 1'b0;
    repeat (20) step();
    P = 12;

    start_pulse();
    wait_phase();
    repeat (P) step();
    i_echo = 1'b1;
    repeat (30 * P) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    i_echo = 1'b0;
    chk("mrst_valid", 32'(o_valid), 0);
    chk("mrst_busy", 32'(o_busy), 0);
    chk("mrst_width", 32'(o_width_us), 0);
    chk("mrst_dist", 32'(o_dist_cm), 0);
    chk("mrst_to", 32'(o_timeout), 0);
    v0 = vcnt;
    repeat (60) step();
    chk("mrst_noval", vcnt - v0, 0);
    run_pulse("after_rst", 3, 200, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      run_pulse($sformatf("rand%0d", i), $urandom_range(1, 20),
                $urandom_range(1, 120), 1'($urandom_range(0, 1)), 1'b0);
    end

`ifdef ECHO_FILTER_EN
    run_pulse("filt", 20, 580, 1'b0, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
